// File: rtl/matrix_frame_loader.sv
// Write side of the render matrix interface: streams 16 column-major words into a shadow
// buffer and publishes them to the live bus only on a frame-sync pulse.
module matrix_frame_loader #(
   parameter int W = 21,
   parameter int N = 16
) (
   input  logic             CLK,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [W-1:0]     in_data,
   input  logic             in_sof,
   input  logic [3:0]       in_state,
   input  logic             frame_sync,
   output logic [N*W-1:0]   mtrxIn,
   output logic [3:0]       matrixState,
   output logic             upd,
   output logic             load_err,
   output logic             busy,
   output logic [1:0]       dbg_state
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOAD   = 2'd1,
      PEND   = 2'd2,
      COMMIT = 2'd3
   } state_t;

   // Identity in column-major order: d11 (slot 0), d22 (5), d33 (10), d44 (15).
   localparam logic [N*W-1:0] IDENT = {
      21'd1024, 84'd0,
      21'd1024, 84'd0,
      21'd1024, 84'd0,
      21'd1024
   };

   state_t           state_q;
   logic [3:0]       idx_q;
   logic [N*W-1:0]   shadow_q;
   logic [3:0]       cap_state_q;
   logic [N*W-1:0]   mtrx_q;
   logic [3:0]       mstate_q;
   logic             upd_q;
   logic             err_q;
   logic             accept;

   // Handshake: a word transfers on a rising edge where in_valid && in_ready; in_ready is
   // a pure function of the registered state, so it never depends on in_valid.
   assign in_ready    = (state_q == IDLE) || (state_q == LOAD);
   assign accept      = in_valid && in_ready;
   assign busy        = (state_q == LOAD) || (state_q == PEND) || (state_q == COMMIT);
   assign mtrxIn      = mtrx_q;
   assign matrixState = mstate_q;
   assign upd         = upd_q;
   assign load_err    = err_q;
   assign dbg_state   = state_q;

   always_ff @(posedge CLK or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         idx_q       <= 4'd0;
         shadow_q    <= '0;
         cap_state_q <= 4'd0;
         mtrx_q      <= IDENT;
         mstate_q    <= 4'd0;
         upd_q       <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         upd_q <= 1'b0;
         err_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (accept) begin
                  if (in_sof) begin
                     shadow_q[N*W-1 -: W] <= in_data;
                     cap_state_q          <= in_state;
                     idx_q                <= 4'd1;
                     state_q              <= LOAD;
                  end else begin
                     err_q <= 1'b1;
                  end
               end
            end
            LOAD: begin
               if (accept) begin
                  if (in_sof) begin
                     // A new sof abandons the partial matrix and restarts it in place.
                     err_q                <= 1'b1;
                     shadow_q[N*W-1 -: W] <= in_data;
                     cap_state_q          <= in_state;
                     idx_q                <= 4'd1;
                  end else begin
                     shadow_q[N*W-1-W*int'(idx_q) -: W] <= in_data;
                     idx_q                               <= idx_q + 4'd1;
                     if (idx_q == 4'd15) begin
                        state_q <= PEND;
                     end
                  end
               end
            end
            PEND: begin
               if (frame_sync) begin
                  state_q <= COMMIT;
               end
            end
            COMMIT: begin
               mtrx_q   <= shadow_q;
               mstate_q <= cap_state_q;
               upd_q    <= 1'b1;
               state_q  <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_matrix_frame_loader.sv
// Directed bench for matrix_frame_loader: reset, load/commit, restart, stray words,
// sync-on-last-word boundary and reset while a matrix is pending.
module tb_matrix_frame_loader;

   localparam int W = 21;
   localparam int N = 16;

   logic           CLK = 1'b0;
   logic           rst = 1'b0;
   logic           in_valid = 1'b0;
   logic           in_ready;
   logic [W-1:0]   in_data = '0;
   logic           in_sof = 1'b0;
   logic [3:0]     in_state = 4'd0;
   logic           frame_sync = 1'b0;
   logic [N*W-1:0] mtrxIn;
   logic [3:0]     matrixState;
   logic           upd;
   logic           load_err;
   logic           busy;
   logic [1:0]     dbg_state;

   int checks = 0;
   int failures = 0;
   int err_cnt = 0;
   int upd_cnt = 0;
   logic [N*W-1:0] ident;
   logic [N*W-1:0] live_exp;

   matrix_frame_loader #(.W(W), .N(N)) dut (
      .CLK         (CLK),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_data     (in_data),
      .in_sof      (in_sof),
      .in_state    (in_state),
      .frame_sync  (frame_sync),
      .mtrxIn      (mtrxIn),
      .matrixState (matrixState),
      .upd         (upd),
      .load_err    (load_err),
      .busy        (busy),
      .dbg_state   (dbg_state)
   );

   always #5 CLK = ~CLK;

   function automatic logic [N*W-1:0] mk_exp(input logic [W-1:0] first, input logic [W-1:0] base);
      logic [N*W-1:0] m;
      m = '0;
      m[N*W-1 -: W] = first;
      for (int k = 1; k < N; k++) begin
         m[N*W-1-W*k -: W] = base + W'(k);
      end
      return m;
   endfunction

   // Called and returns at a falling edge; the rising edge in between takes the word.
   task automatic send_word(input logic [W-1:0] d, input logic sof, input logic [3:0] st);
      in_valid = 1'b1;
      in_data  = d;
      in_sof   = sof;
      in_state = st;
      @(negedge CLK);
      in_valid = 1'b0;
      in_sof   = 1'b0;
      if (load_err) err_cnt++;
      if (upd) upd_cnt++;
   endtask

   task automatic send_matrix(input logic [W-1:0] first, input logic [3:0] st,
                              input logic [W-1:0] base, input logic sync_on_last);
      send_word(first, 1'b1, st);
      for (int k = 1; k < N; k++) begin
         if (k == N - 1 && sync_on_last) frame_sync = 1'b1;
         send_word(base + W'(k), 1'b0, 4'hF);
         frame_sync = 1'b0;
      end
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge CLK);
         if (load_err) err_cnt++;
         if (upd) upd_cnt++;
      end
   endtask

   task automatic test_reset();
      checks++; if (mtrxIn !== ident) begin failures++; $display("FAIL reset_mtrx got=%h exp=%h", mtrxIn, ident); end
      checks++; if (matrixState !== 4'd0) begin failures++; $display("FAIL reset_state got=%h exp=0", matrixState); end
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", in_ready); end
      checks++; if (upd !== 1'b0) begin failures++; $display("FAIL reset_upd got=%b exp=0", upd); end
      checks++; if (load_err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", load_err); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
      checks++; if (dbg_state !== 2'd0) begin failures++; $display("FAIL reset_dbg got=%0d exp=0", dbg_state); end
   endtask

   task automatic test_full_load();
      logic [N*W-1:0] exp_m;
      exp_m = mk_exp(21'd1, 21'd1);
      err_cnt = 0;
      send_matrix(21'd1, 4'h5, 21'd1, 1'b0);
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL pend_ready got=%b exp=0", in_ready); end
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL pend_busy got=%b exp=1", busy); end
      idle_cycles(3);
      checks++; if (mtrxIn !== ident) begin failures++; $display("FAIL pend_mtrx got=%h exp=%h", mtrxIn, ident); end
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL pend_ready_hold got=%b exp=0", in_ready); end
      frame_sync = 1'b1;
      @(negedge CLK);
      frame_sync = 1'b0;
      checks++; if (mtrxIn !== ident) begin failures++; $display("FAIL commit_edge1_mtrx got=%h exp=%h", mtrxIn, ident); end
      checks++; if (upd !== 1'b0) begin failures++; $display("FAIL commit_edge1_upd got=%b exp=0", upd); end
      @(negedge CLK);
      checks++; if (mtrxIn[335:315] !== 21'd1) begin failures++; $display("FAIL full_d11 got=%h exp=1", mtrxIn[335:315]); end
      checks++; if (mtrxIn[20:0] !== 21'd16) begin failures++; $display("FAIL full_d44 got=%h exp=10", mtrxIn[20:0]); end
      checks++; if (mtrxIn !== exp_m) begin failures++; $display("FAIL full_mtrx got=%h exp=%h", mtrxIn, exp_m); end
      checks++; if (matrixState !== 4'h5) begin failures++; $display("FAIL full_state got=%h exp=5", matrixState); end
      checks++; if (upd !== 1'b1) begin failures++; $display("FAIL full_upd got=%b exp=1", upd); end
      @(negedge CLK);
      checks++; if (upd !== 1'b0) begin failures++; $display("FAIL full_upd_pulse got=%b exp=0", upd); end
      checks++; if (in_ready !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL full_back_idle ready=%b busy=%b exp ready=1 busy=0", in_ready, busy); end
      checks++; if (err_cnt !== 0) begin failures++; $display("FAIL full_no_err got=%0d exp=0", err_cnt); end
      live_exp = exp_m;
   endtask

   task automatic test_restart();
      logic [N*W-1:0] exp_m;
      exp_m = mk_exp(21'h1FFFFF, 21'h100);
      err_cnt = 0;
      send_word(21'h0AAAA, 1'b1, 4'h3);
      for (int k = 1; k < 7; k++) send_word(21'h50 + 21'(k), 1'b0, 4'h0);
      send_matrix(21'h1FFFFF, 4'hA, 21'h100, 1'b0);
      frame_sync = 1'b1;
      @(negedge CLK);
      frame_sync = 1'b0;
      @(negedge CLK);
      checks++; if (err_cnt !== 1) begin failures++; $display("FAIL restart_err_count got=%0d exp=1", err_cnt); end
      checks++; if (mtrxIn[335:315] !== 21'h1FFFFF) begin failures++; $display("FAIL restart_d11 got=%h exp=1fffff", mtrxIn[335:315]); end
      checks++; if (mtrxIn !== exp_m) begin failures++; $display("FAIL restart_mtrx got=%h exp=%h", mtrxIn, exp_m); end
      checks++; if (matrixState !== 4'hA) begin failures++; $display("FAIL restart_state got=%h exp=a", matrixState); end
      idle_cycles(1);
      live_exp = exp_m;
   endtask

   task automatic test_stray();
      err_cnt = 0;
      for (int k = 0; k < 3; k++) begin
         send_word(21'h777 + 21'(k), 1'b0, 4'h9);
         checks++; if (busy !== 1'b0) begin failures++; $display("FAIL stray_busy word=%0d got=%b exp=0", k, busy); end
      end
      idle_cycles(1);
      checks++; if (load_err !== 1'b0) begin failures++; $display("FAIL stray_err_clear got=%b exp=0", load_err); end
      checks++; if (err_cnt !== 3) begin failures++; $display("FAIL stray_err_count got=%0d exp=3", err_cnt); end
      checks++; if (mtrxIn !== live_exp) begin failures++; $display("FAIL stray_mtrx got=%h exp=%h", mtrxIn, live_exp); end
   endtask

   task automatic test_back_to_back_sync();
      logic [N*W-1:0] exp_m;
      exp_m = mk_exp(21'h1F000, 21'h1F000);
      upd_cnt = 0;
      send_matrix(21'h1F000, 4'hC, 21'h1F000, 1'b1);
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bnd_pend_ready got=%b exp=0", in_ready); end
      idle_cycles(4);
      checks++; if (upd_cnt !== 0) begin failures++; $display("FAIL bnd_no_upd got=%0d exp=0", upd_cnt); end
      checks++; if (mtrxIn !== live_exp) begin failures++; $display("FAIL bnd_no_commit got=%h exp=%h", mtrxIn, live_exp); end
      frame_sync = 1'b1;
      @(negedge CLK);
      frame_sync = 1'b0;
      @(negedge CLK);
      checks++; if (upd !== 1'b1) begin failures++; $display("FAIL bnd_upd got=%b exp=1", upd); end
      checks++; if (mtrxIn !== exp_m) begin failures++; $display("FAIL bnd_mtrx got=%h exp=%h", mtrxIn, exp_m); end
      checks++; if (matrixState !== 4'hC) begin failures++; $display("FAIL bnd_state got=%h exp=c", matrixState); end
      idle_cycles(1);
      live_exp = exp_m;
   endtask

   task automatic test_reset_pend();
      send_matrix(21'h33, 4'h7, 21'h40, 1'b0);
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL rstpend_busy got=%b exp=1", busy); end
      #2;
      rst = 1'b0;
      #1;
      checks++; if (mtrxIn !== ident) begin failures++; $display("FAIL rstpend_async_mtrx got=%h exp=%h", mtrxIn, ident); end
      @(negedge CLK);
      rst = 1'b1;
      checks++; if (matrixState !== 4'd0 || in_ready !== 1'b1) begin failures++; $display("FAIL rstpend_state state=%h ready=%b exp state=0 ready=1", matrixState, in_ready); end
      upd_cnt = 0;
      frame_sync = 1'b1;
      @(negedge CLK);
      frame_sync = 1'b0;
      idle_cycles(4);
      checks++; if (upd_cnt !== 0) begin failures++; $display("FAIL rstpend_no_upd got=%0d exp=0", upd_cnt); end
      checks++; if (mtrxIn !== ident) begin failures++; $display("FAIL rstpend_mtrx got=%h exp=%h", mtrxIn, ident); end
   endtask

   initial begin
      ident = '0;
      ident[335:315] = 21'd1024;
      ident[230:210] = 21'd1024;
      ident[125:105] = 21'd1024;
      ident[20:0]    = 21'd1024;
      live_exp = ident;
      @(negedge CLK);
      @(negedge CLK);
      rst = 1'b1;
      @(negedge CLK);
      test_reset();
      test_full_load();
      test_restart();
      test_stray();
      test_back_to_back_sync();
      test_reset_pend();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
